// File: rtl/measure_pt_regs.sv
// Measurement point capture block with a Wishbone classic register front end.
// Each channel owns a one-entry pending slot; the lowest occupied slot drains
// into a shared point FIFO that software pops through the FIFO register.

// One channel's pending slot: holds a captured point until the FIFO takes it.
module measure_pt_slot #(
  parameter logic [2:0] CH = 3'd0
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        flush_i,
  input  logic        vld_i,
  input  logic        drain_i,
  input  logic [9:0]  t_i,
  input  logic [15:0] v_i,
  output logic        occ_o,
  output logic        drop_o,
  output logic [28:0] ent_o
);
  logic        occ_q;
  logic [28:0] ent_q;
  logic        load;

  // A slot being drained this cycle can refill in the same cycle; flush discards everything.
  assign load   = vld_i & (~occ_q | drain_i) & ~flush_i;
  assign drop_o = vld_i & occ_q & ~drain_i & ~flush_i;
  assign occ_o  = occ_q;
  assign ent_o  = ent_q;

  // Slot occupancy and captured {ch, t, v}.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      occ_q <= 1'b0;
      ent_q <= '0;
    end else begin
      if (flush_i)      occ_q <= 1'b0;
      else if (load)    occ_q <= 1'b1;
      else if (drain_i) occ_q <= 1'b0;
      if (load) ent_q <= {CH, t_i, v_i};
    end
  end
endmodule

module measure_pt_regs #(
  parameter int          N_CH                = 2,
  parameter int          FIFO_DEPTH          = 16,
  parameter logic [9:0]  DEFAULT_DELAY_DELTA = 10'h1,
  parameter logic [15:0] DEFAULT_THR_DELTA   = 16'h1
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic [31:0]          wb_dat_i,
  output logic [31:0]          wb_dat_o,
  input  logic [31:0]          wb_adr_i,
  input  logic                 wb_we_i,
  input  logic [3:0]           wb_sel_i,
  input  logic                 wb_cyc_i,
  input  logic                 wb_stb_i,
  output logic                 wb_ack_o,
  input  logic [N_CH-1:0]      pt_vld_i,
  input  logic [N_CH*16-1:0]   pt_v_i,
  input  logic [N_CH*10-1:0]   pt_t_i,
  output logic [N_CH*26-1:0]   ch_delta_o,
  output logic [15:0]          thr_code_o,
  output logic [N_CH-1:0]      thr_wre_o,
  input  logic [N_CH-1:0]      thr_rdy_i,
  output logic                 run_o,
  output logic                 irq_o
);
  localparam int AW = $clog2(FIFO_DEPTH);

  // Bus state and registers
  logic                   ack_q;
  logic [31:0]            dat_q, rdat;
  logic                   run_q, irq_en_q, ovf_q, irq_q;
  logic [N_CH-1:0]        thr_wre_q;
  logic [15:0]            thr_code_q;
  logic [N_CH-1:0][25:0]  delta_q;

  // FIFO state
  logic [28:0]            mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [AW:0]            cnt_q;
  logic [8:0]             cnt9;
  logic [7:0]             cnt8;
  logic                   empty, full, push, pop;
  logic [28:0]            head, ent_sel;

  // Slot plumbing
  logic [N_CH-1:0]        occ, drop, low_oh, drain, delta_hit;
  logic [N_CH-1:0][28:0]  ent;

  // Decode
  logic [3:0]             ad;
  logic                   req, wr, rd, flush, ctrl_wr, stat_wr, thr_wr;
  logic [25:0]            wm;
  logic                   unused_ok;

  assign req     = wb_cyc_i & wb_stb_i & ~ack_q;
  assign ad      = wb_adr_i[5:2];
  assign wr      = req & wb_we_i;
  assign rd      = req & ~wb_we_i;
  assign ctrl_wr = wr && (ad == 4'd0);
  assign stat_wr = wr && (ad == 4'd1);
  assign thr_wr  = wr && (ad == 4'd2);
  // Action bits (run, flush, W1C, write-enable mask) only fire from enabled byte lanes.
  assign flush   = ctrl_wr & wb_dat_i[1] & wb_sel_i[0];
  assign wm      = {{2{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
  assign unused_ok = ^{wb_adr_i[31:6], wb_adr_i[1:0], wb_dat_i[31:26]};

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign cnt9  = 9'(cnt_q);
  assign cnt8  = cnt9[8] ? 8'hFF : cnt9[7:0];
  assign head  = mem[rd_ptr_q];
  assign pop   = rd && (ad == 4'd3) && !empty;

  // Lowest-index occupied slot wins the single push per cycle.
  assign low_oh = occ & (~occ + 1'b1);
  assign push   = (|occ) & (~full | pop) & ~flush;
  assign drain  = push ? low_oh : '0;

  for (genvar g = 0; g < N_CH; g++) begin : g_slot
    measure_pt_slot #(.CH(3'(g))) u_slot (
      .wb_clk_i (wb_clk_i),
      .wb_rst_i (wb_rst_i),
      .flush_i  (flush),
      .vld_i    (pt_vld_i[g]),
      .drain_i  (drain[g]),
      .t_i      (pt_t_i[g*10 +: 10]),
      .v_i      (pt_v_i[g*16 +: 16]),
      .occ_o    (occ[g]),
      .drop_o   (drop[g]),
      .ent_o    (ent[g])
    );
    assign delta_hit[g] = (ad == 4'(4 + g));
  end

  // Select the draining slot's entry.
  always_comb begin
    ent_sel = '0;
    for (int i = 0; i < N_CH; i++)
      if (low_oh[i]) ent_sel = ent[i];
  end

  // Read data mux for the addressed register.
  always_comb begin
    rdat = 32'h0;
    case (ad)
      4'd0: rdat = {16'h0, 8'(N_CH), 5'h0, irq_en_q, 2'b00};
      4'd1: rdat = {16'h0, cnt8, 5'h0, ovf_q, full, empty};
      4'd2: rdat = {{(32-N_CH){1'b0}}, thr_rdy_i};
      4'd3: rdat = empty ? 32'h0 : {head[28:26], 3'b000, head[25:16], head[15:0]};
      default: begin
        for (int i = 0; i < N_CH; i++)
          if (delta_hit[i]) rdat = {6'h0, delta_q[i]};
      end
    endcase
  end

  // Bus handshake, control registers and one-cycle strobes.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q      <= 1'b0;
      dat_q      <= 32'h0;
      run_q      <= 1'b0;
      thr_wre_q  <= '0;
      thr_code_q <= 16'h0;
      irq_en_q   <= 1'b0;
      ovf_q      <= 1'b0;
      irq_q      <= 1'b0;
      for (int i = 0; i < N_CH; i++)
        delta_q[i] <= {DEFAULT_DELAY_DELTA, DEFAULT_THR_DELTA};
    end else begin
      ack_q     <= req;
      dat_q     <= rd ? rdat : 32'h0;
      run_q     <= ctrl_wr & wb_dat_i[0] & wb_sel_i[0];
      thr_wre_q <= thr_wr ? (wb_dat_i[16 +: N_CH] & {N_CH{wb_sel_i[2]}}) : '0;
      if (ctrl_wr && wb_sel_i[0]) irq_en_q <= wb_dat_i[2];
      if (thr_wr) thr_code_q <= (thr_code_q & ~wm[15:0]) | (wb_dat_i[15:0] & wm[15:0]);
      for (int i = 0; i < N_CH; i++)
        if (wr && delta_hit[i]) delta_q[i] <= (delta_q[i] & ~wm) | (wb_dat_i[25:0] & wm);
      // A drop in the same cycle as the clear keeps ovf set so no loss goes unseen.
      if (|drop)                               ovf_q <= 1'b1;
      else if (stat_wr && wb_sel_i[0] && wb_dat_i[2]) ovf_q <= 1'b0;
      irq_q <= irq_en_q & (~empty | ovf_q);
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (!push && pop) cnt_q <= cnt_q - 1'b1;
    end
  end

  // FIFO storage.
  always_ff @(posedge wb_clk_i) begin
    if (push) mem[wr_ptr_q] <= ent_sel;
  end

  assign wb_ack_o   = ack_q;
  assign wb_dat_o   = dat_q;
  assign run_o      = run_q;
  assign thr_wre_o  = thr_wre_q;
  assign thr_code_o = thr_code_q;
  assign irq_o      = irq_q;
  assign ch_delta_o = delta_q;
endmodule

// File: doc/measure_pt_regs.md
MEASURE_PT_REGS -- requirements
Module: measure_pt_regs

Interface
REQ-001 SHALL have parameter N_CH, default 2, number of measurement channels, legal range 1..8.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, point FIFO entries, power of 2, range 4..256.
REQ-003 SHALL have parameter DEFAULT_DELAY_DELTA, default 10'h1, reset value of each channel's delay-delta field.
REQ-004 SHALL have parameter DEFAULT_THR_DELTA, default 16'h1, reset value of each channel's threshold-delta field.
REQ-005 SHALL have ports: wb_clk_i in 1 clock; wb_rst_i in 1 reset, asynchronous, active-high.
REQ-006 SHALL have ports: wb_dat_i in 32, wb_dat_o out 32, wb_adr_i in 32, wb_we_i in 1, wb_sel_i in 4, wb_cyc_i in 1, wb_stb_i in 1, wb_ack_o out 1 (Wishbone classic slave).
REQ-007 SHALL have ports: pt_vld_i in N_CH, point-valid pulse per channel; pt_v_i in N_CH*16, threshold value; pt_t_i in N_CH*10, delay code; channel i in slice i. All are synchronous to wb_clk_i.
REQ-008 SHALL have ports: ch_delta_o out N_CH*26, per channel {delay delta[25:16], threshold delta[15:0]}; thr_code_o out 16; thr_wre_o out N_CH; thr_rdy_i in N_CH; run_o out 1; irq_o out 1.

Function
REQ-009 SHALL decode the word address as wb_adr_i[5:2]: 0 CTRL, 1 STATUS, 2 THR, 3 FIFO, 4..4+N_CH-1 DELTA[ch]; all other addresses read 0, ignore writes, and still ack.
REQ-010 SHALL assert wb_ack_o for exactly one cycle, on the cycle after wb_cyc_i&wb_stb_i&!wb_ack_o, with wb_dat_o valid in the same cycle; the register side effect occurs once per ack.
REQ-011 SHALL merge writes per byte: a byte lane with wb_sel_i[k]=0 keeps its current register value.
REQ-012 CTRL write: bit0=1 SHALL pulse run_o for 1 cycle; bit1=1 SHALL flush the FIFO and all pending slots; bit2 SHALL store irq_en. CTRL read: {16'b0, N_CH[7:0], 5'b0, irq_en, 2'b0}.
REQ-013 STATUS read SHALL return {16'b0, count[7:0] (saturated at 255), 5'b0, ovf, full, empty}; a write with bit2=1 SHALL clear ovf (write-1-to-clear).
REQ-014 THR write SHALL latch thr_code_o<=w[15:0] and pulse thr_wre_o[i] for 1 cycle for every i<N_CH with w[16+i]=1; mask bits at or above N_CH are ignored. THR read SHALL return thr_rdy_i, zero-extended.
REQ-015 DELTA[ch] SHALL be r/w, 26 bits; bits 31:26 read 0 and are not stored.
REQ-016 Capture: each channel SHALL have a 1-entry pending slot {ch[2:0], t[9:0], v[15:0]}; pt_vld_i[i] loads slot i when slot i is empty.
REQ-017 pt_vld_i[i] while slot i is occupied and not being drained in that cycle SHALL drop the new point and set ovf.
REQ-018 Each cycle, the lowest-index occupied slot SHALL be pushed to the FIFO if it is not full (or if it is full and a pop happens in the same cycle); at most one push per cycle.
REQ-019 A slot drained in cycle n SHALL accept a new pt_vld_i in cycle n; the capture-to-FIFO latency is 2 cycles (slot load, push).
REQ-020 FIFO read SHALL return {ch[2:0], 3'b0, t[9:0], v[15:0]} from the head and pop it; a read of an empty FIFO SHALL return 0 and not pop.
REQ-021 Simultaneous push and pop SHALL leave count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-022 Flush SHALL win over a same-cycle push or capture; those points are discarded without setting ovf.
REQ-023 irq_o SHALL be registered: irq_en & (!empty | ovf).

Reset
REQ-024 On wb_rst_i SHALL set: wb_ack_o=0, wb_dat_o=0, run_o=0, thr_wre_o=0, thr_code_o=0, irq_o=0, irq_en=0, ovf=0, FIFO empty, all slots empty, each DELTA={DEFAULT_DELAY_DELTA, DEFAULT_THR_DELTA}.
REQ-025 Reset asserted mid-transaction SHALL abort the transaction without an ack; the bus transaction is not resumed after release.

Verification
REQ-026 After reset, read DELTA[1] -> 0x00010001; write 0x03FF0020 with sel=4'b0011 -> read back 0x00010020.
REQ-027 Write THR 0x0003ABCD, N_CH=2 -> thr_code_o=0xABCD, thr_wre_o=2'b11 for exactly 1 cycle; mask 0xFF -> same, no X.
REQ-028 Same-cycle pt_vld_i=2'b11, ch0 (v=5, t=7), ch1 (v=9, t=3) -> FIFO reads give 0x00070005, then 0x20030009, then 0.
REQ-029 Push FIFO_DEPTH+2 points on ch0 without reads -> full=1, then ovf=1 on the next vld; W1C clears ovf; count=FIFO_DEPTH.
REQ-030 irq_en=1 with one point captured -> irq_o rises 3 cycles after pt_vld_i; CTRL flush -> empty=1 and irq_o=0 on the following cycle.
